mw_addsub: RTL
==============

Name: mw_addsub

Overview:
- Word-serial multi-word adder/subtractor for the CIOS datapath; generalises the single-word S+C carry split to an N-word operand with a carry chain held across words.
- Used for CIOS accumulation and the final conditional subtraction of the modulus.
- Operand words stream in LSW-first over a valid/ready handshake; result words stream out with backpressure.
- Final carry or borrow is reported together with a one-cycle done pulse.

Parameters:
- WIDTH, 32: word width in bits.
- NWORDS, 8: words per operand, must be >= 1.
- CNT_W, $clog2(NWORDS+1): word counter width, derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0=add, 1=subtract (A-B); latched on start
- cin  in  1  carry-in (add) / borrow-in (sub); latched on start
- a_word  in  WIDTH  operand A word, LSW first
- b_word  in  WIDTH  operand B word, LSW first
- in_valid  in  1  a_word/b_word valid
- in_ready  out  1  block accepts a word pair this cycle
- out_word  out  WIDTH  result word
- out_last  out  1  out_word is word NWORDS-1
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts out_word
- cout  out  1  final carry (add) / borrow (sub); held until next start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state=IDLE, carry reg=0, word count=0; out_word=0, out_valid=0, out_last=0, cout=0, done=0, in_ready=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch mode; carry <= mode ? ~cin : cin; count <= 0; go to RUN. start is ignored outside IDLE.
- RUN, in_ready rule: in_ready = (state==RUN) && (!out_valid || out_ready). It is purely combinational from state/out_valid/out_ready and does not depend on in_valid.
- RUN, accept: a word pair is accepted when in_valid && in_ready.
  - t = a_word + (mode ? ~b_word : b_word) + carry, computed WIDTH+1 bits wide.
  - Registered next cycle: out_word <= t[WIDTH-1:0], carry <= t[WIDTH], out_valid <= 1, out_last <= (count==NWORDS-1), count++.
- Output latency: one cycle from acceptance to out_valid.
- out_valid clears on handshake unless a new pair is accepted in the same cycle. This gives full throughput of one word per cycle.
- Output hold: out_word and out_last stay stable while out_valid && !out_ready.
- RUN -> DRAIN when the NWORDS-th pair is accepted. No further input is accepted; in_ready=0.
- DRAIN -> DONE on the handshake of the out_last word.
- DONE: done=1 for exactly one cycle; cout <= mode ? ~carry : carry; then go to IDLE.
- cout is updated in the same cycle done is asserted and is held until the next start.
- NWORDS=1: the first acceptance goes straight to DRAIN.
- Bubbles: in_valid low inserts bubbles; the carry is held unchanged.
- rst mid-operation: returns immediately to reset values; any partial result is discarded and no done pulse is issued.
- Operands are unsigned. Sub result is A-B mod 2^(WIDTH*NWORDS), with cout=1 iff A < B + borrow-in.

Decomposition:
- Package cios_pkg holds the state_t enum (IDLE, RUN, DRAIN, DONE) and the MODE_ADD/MODE_SUB constants.
- One sub-module, mw_word_addc: combinational WIDTH-bit add with carry-in, optional invert of B, and a {carry, sum} output.
- The FSM, counter and output register stay in mw_addsub.

Test Plan (WIDTH=8, NWORDS=4 unless noted):
- Add, A=0x01FFFFFF, B=0x00000001, cin=0, continuous valid and ready -> out words 0x00,0x00,0x00,0x02 (LSW first), out_last on word 4, cout=0, done one cycle after the last handshake.
- Add, A=0xFFFFFFFF, B=0x00000001 -> all result words 0x00, cout=1.
- Sub, A=0x00000000, B=0x00000001, cin=0 -> all result words 0xFF, cout(borrow)=1; Sub, A=0x12345678, B=0x12345678 -> 0x00000000, cout=0.
- Backpressure: out_ready low for 3 cycles after the 2nd word -> out_word held stable, in_ready=0 throughout, no words lost or duplicated; in_valid gaps mid-operand -> same result as the no-gap case.
- Control: start asserted during RUN is ignored; rst asserted after 2 words -> outputs return to reset values, no done; the next start completes correctly.
- NWORDS=1, WIDTH=32: 0xFFFFFFFF + 0x00000001, cin=1 -> out 0x00000001, cout=1, out_last on the single word.

Source files
------------

// File: rtl/cios_pkg.sv
// Shared types and constants for the CIOS multi-word datapath blocks.
// Holds the sequencer state encoding and the add/subtract mode values,
// plus a helper for the carry/borrow polarity swap used in subtraction.
package cios_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Subtraction is done as A + ~B + carry, where carry = ~borrow.
    // The same inversion converts borrow-in to carry-in and the final
    // carry back to a borrow-out, so one helper serves both directions.
    function automatic logic sub_flip(input logic mode, input logic bit_in);
        return (mode == MODE_SUB) ? ~bit_in : bit_in;
    endfunction

endpackage

// File: rtl/mw_word_addc.sv
// Single-word adder with carry-in and optional inversion of the B operand.
// Produces a WIDTH+1 bit result whose top bit is the carry into the next word.
module mw_word_addc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             invert_b,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] b_eff;

    // Invert B for subtraction, then add all three terms one bit wider
    // than the word so the carry-out lands in sum[WIDTH].
    always_comb begin
        b_eff = invert_b ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/mw_addsub.sv
// Word-serial multi-word adder/subtractor.
// Operand words arrive LSW first over a valid/ready handshake; each accepted
// pair is added (or subtracted) with the carry held from the previous word
// and the result word is registered into a single-entry output stage that
// supports downstream backpressure. The final carry/borrow is reported on
// cout together with a one-cycle done pulse.
module mw_addsub
    import cios_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic               mode_r;
    logic               carry;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     sum;
    logic               accept;
    logic               last_accept;
    logic               out_hs;

    mw_word_addc #(
        .WIDTH    (WIDTH)
    ) u_addc (
        .a        (a_word),
        .b        (b_word),
        .cin      (carry),
        .invert_b (mode_r),
        .sum      (sum)
    );

    // Handshake decode: input is accepted only while running and the output
    // stage is either empty or being emptied this same cycle.
    always_comb begin
        in_ready    = (state == RUN) && (!out_valid || out_ready);
        accept      = in_valid && in_ready;
        last_accept = accept && (count == LAST_IDX);
        out_hs      = out_valid && out_ready;
        busy        = (state != IDLE);
    end

    // Sequencer next-state: run until the last pair is taken, drain the
    // final result word, then spend one cycle in DONE for the pulse.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (out_hs && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operation setup on start, carry chain and output stage
    // while running, and the completion report when the last word leaves.
    // done is raised on the edge that enters DONE so that it and the new
    // cout value become visible in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= MODE_ADD;
            carry     <= 1'b0;
            count     <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        carry  <= sub_flip(mode, cin);
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_word  <= sum[WIDTH-1:0];
                        carry     <= sum[WIDTH];
                        out_valid <= 1'b1;
                        out_last  <= last_accept;
                        count     <= count + CNT_ONE;
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done <= 1'b1;
                            cout <= sub_flip(mode_r, carry);
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
